// File: rtl/l2_data_array_pkg.sv
// Shared L2 line geometry, index/line types and a byte parity helper
// used by the L2 data array and its parity generator.
package l2_data_array_pkg;

  localparam int L2_LINE_W     = 256;
  localparam int L2_LINE_BYTES = L2_LINE_W / 8;
  localparam int L2_DEPTH      = 8;
  localparam int L2_IDX_W      = $clog2(L2_DEPTH);

  typedef logic [L2_IDX_W-1:0]  l2_index_t;
  typedef logic [L2_LINE_W-1:0] l2_line_t;

  // Even parity: the stored bit makes the byte plus parity bit XOR to zero.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/l2_data_array_if.sv
// Request/response bundle between the L2 controller (master) and one
// way of the L2 data array (slave).
interface l2_data_array_if
  import l2_data_array_pkg::*;
#(
  parameter int WIDTH = L2_LINE_W,
  parameter int DEPTH = L2_DEPTH
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int NBYTES = WIDTH / 8;

  logic              read;
  logic              write;
  logic [IDX_W-1:0]  index;
  logic [NBYTES-1:0] mask;
  logic [WIDTH-1:0]  datain;
  logic [WIDTH-1:0]  dataout;
  logic              resp_valid;
  logic              ready;
  logic              parity_err;

  modport master (
    output read, write, index, mask, datain,
    input  dataout, resp_valid, ready, parity_err
  );

  modport slave (
    input  read, write, index, mask, datain,
    output dataout, resp_valid, ready, parity_err
  );

endinterface

// File: rtl/l2_parity_gen.sv
// Combinational per-byte even-parity generator: one parity bit for
// each byte of a WIDTH-bit line.
module l2_parity_gen
  import l2_data_array_pkg::*;
#(
  parameter int WIDTH = L2_LINE_W
) (
  input  logic [WIDTH-1:0]   data,
  output logic [WIDTH/8-1:0] parity
);

  always_comb begin
    parity = '0;
    for (int i = 0; i < WIDTH / 8; i++) begin
      parity[i] = byte_parity(data[8*i +: 8]);
    end
  end

endmodule

// File: rtl/l2_data_array.sv
// L2 cache data store for one way: byte-masked writes, 1-cycle registered
// reads, self-clearing sweep after reset. L2_DATA_ARRAY_PARITY_EN adds per-byte parity.
module l2_data_array
  import l2_data_array_pkg::*;
#(
  parameter int WIDTH = L2_LINE_W,
  parameter int DEPTH = L2_DEPTH
) (
  input logic            clk,
  input logic            rst,
  l2_data_array_if.slave bus
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int NBYTES = WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  ptr, ptr_next;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic [WIDTH-1:0]  byte_mask;
  logic [WIDTH-1:0]  old_line;
  logic [WIDTH-1:0]  merged_line;
  logic [WIDTH-1:0]  rd_line;
  logic [WIDTH-1:0]  wr_data;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_en;
  logic              ready_c;
  logic              rd_acc;
  logic              parity_hit;

  logic [WIDTH-1:0]  dataout_q;
  logic              resp_valid_q;
  logic              parity_err_q;

  assign ready_c = (state == IDLE);
  assign rd_acc  = ready_c & bus.read;

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      byte_mask[8*i +: 8] = {8{bus.mask[i]}};
    end
  end

  // Read and write share one index, so a simultaneous write always hits the
  // line being read; the merged line is returned (write-first).
  assign old_line    = mem[bus.index];
  assign merged_line = (bus.datain & byte_mask) | (old_line & ~byte_mask);
  assign rd_line     = bus.write ? merged_line : old_line;

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    wr_en      = 1'b0;
    wr_idx     = bus.index;
    wr_data    = merged_line;
    case (state)
      CLEAR: begin
        wr_en    = 1'b1;
        wr_idx   = ptr;
        wr_data  = '0;
        ptr_next = ptr + 1'b1;
        if (ptr == LAST_IDX) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        wr_en = bus.write;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

`ifdef L2_DATA_ARRAY_PARITY_EN
  logic [NBYTES-1:0] par_mem [DEPTH];
  logic [NBYTES-1:0] wr_par_gen;
  logic [NBYTES-1:0] rd_par_gen;
  logic [NBYTES-1:0] old_par;
  logic [NBYTES-1:0] merged_par;
  logic [NBYTES-1:0] wr_par;
  logic [NBYTES-1:0] rd_par;

  l2_parity_gen #(.WIDTH(WIDTH)) u_wr_par (
    .data   (bus.datain),
    .parity (wr_par_gen)
  );

  l2_parity_gen #(.WIDTH(WIDTH)) u_rd_par (
    .data   (rd_line),
    .parity (rd_par_gen)
  );

  assign old_par    = par_mem[bus.index];
  assign merged_par = (wr_par_gen & bus.mask) | (old_par & ~bus.mask);
  assign wr_par     = (state == CLEAR) ? '0 : merged_par;
  assign rd_par     = bus.write ? merged_par : old_par;
  assign parity_hit = |(rd_par_gen ^ rd_par);
`else
  assign parity_hit = 1'b0;
`endif

  // Storage has no reset of its own; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_idx] <= wr_data;
`ifdef L2_DATA_ARRAY_PARITY_EN
      par_mem[wr_idx] <= wr_par;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLEAR;
      ptr          <= '0;
      dataout_q    <= '0;
      resp_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state        <= state_next;
      ptr          <= ptr_next;
      resp_valid_q <= rd_acc;
      parity_err_q <= rd_acc & parity_hit;
      if (rd_acc) begin
        dataout_q <= rd_line;
      end
    end
  end

  assign bus.dataout    = dataout_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.ready      = ready_c;
`ifdef L2_DATA_ARRAY_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
